// File: rtl/usrt_trans.sv
// USRT transmitter: generates the free-running link clock usrt_clk from clk and shifts
// one byte per handshake out on tx as a 10-bit frame, changing bits on usrt_clk falling edges.
module usrt_trans #(
    parameter int HALF_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       usrt_clk
);

    // state | meaning
    // IDLE  | line high, ready for a byte
    // ARM   | byte latched, waiting for the first fall event after acceptance
    // START | start bit (0) on the line
    // DATA  | data bits, LSB first; bit_cnt is the bit currently on the line
    // STOP  | stop bit (1) on the line; ready returns at the next fall event
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        STOP
    } state_t;

    localparam int            DW      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(HALF_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div;
    logic [7:0]    shreg, shreg_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          tx_nxt, ready_nxt;
    logic          fall;

    // A fall event is the divider wrap that takes usrt_clk from 1 to 0.
    assign fall = (div == DIV_MAX) && usrt_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            usrt_clk <= 1'b0;
        end else if (div == DIV_MAX) begin
            div      <= '0;
            usrt_clk <= ~usrt_clk;
        end else begin
            div <= div + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx;
        ready_nxt   = ready;
        case (state)
            IDLE: begin
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                // Acceptance ignores a coincident fall event so the start bit is never truncated.
                if (send) begin
                    shreg_nxt = data;
                    ready_nxt = 1'b0;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (fall) begin
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (fall) begin
                    tx_nxt      = shreg[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (fall) begin
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/usrt_trans.md
# usrt_trans

Synchronous serial (USRT) transmitter for the calculator's serial link: accepts one byte per handshake, generates the free-running link clock `usrt_clk` from the system clock and shifts the byte out on `tx` as a 10-bit frame. It is the stage directly upstream of `usrt_rec`: `usrt_trans.tx` drives `usrt_rec.rx` and `usrt_trans.usrt_clk` drives `usrt_rec.usrt_clk`. Bits change on `usrt_clk` falling edges so the receiver samples them mid-bit on rising edges.

## Interface
- `HALF_DIV`, default 1: `clk` cycles per `usrt_clk` half-period (≥1). The default gives `usrt_clk` = `clk`/2.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `data` input 8: byte to send; sampled only on acceptance.
- `send` input 1: request to transmit `data`.
- `ready` output 1: high when a new byte can be accepted.
- `tx` output 1: serial data line; idles high.
- `usrt_clk` output 1: link clock, free-running, 50% duty.

## Operation
- **Reset values:** `usrt_clk`=0, `tx`=1, `ready`=1, divider=0, bit counter=0, state IDLE.
- **Clock generator:**
  - Divider counts 0..HALF_DIV-1. At HALF_DIV-1 it wraps to 0 and toggles `usrt_clk`.
  - A *fall event* is a toggle while `usrt_clk`=1.
  - The generator runs in every state, including IDLE.
- **Frame format:** start bit 0, then `data[0]`..`data[7]` (LSB first), then stop bit 1. Each bit lasts exactly one `usrt_clk` period, from one falling edge to the next.
- **Handshake:**
  - `send`=1 while `ready`=1 at a `clk` edge means the byte is accepted. `data` is latched into the shift register, `ready` goes 0 on that edge, and the state goes to ARM.
  - `send` is ignored while `ready`=0. `data` may change freely after acceptance.
- **States:**
  - IDLE: `tx`=1, `ready`=1. `send` moves to ARM.
  - ARM: wait for the first fall event strictly after the acceptance edge. On that event drive `tx`=0 and go to START.
  - START: at the next fall event drive `tx`=`data[0]`, set bit counter to 0, go to DATA.
  - DATA: on each fall event, shift and increment the counter. After bit 7 has lasted one full period, drive `tx`=1 and go to STOP.
  - STOP: at the next fall event go to IDLE and set `ready`=1. `tx` stays 1.
- **Back-to-back:** `send` held high in the cycle after `ready` rises is accepted. The next start bit begins at the following fall event, so the stop bit plus idle gap is ≥1 bit period.
- **Simultaneous events:** `send` in the same cycle as a fall event while in IDLE is accepted into ARM. The start bit waits for the *next* fall event, so it is never truncated.
- **Reset mid-frame:** immediately returns every output and register to its reset value. A partial frame is abandoned and `tx` returns to 1 asynchronously.

## Timing
- `usrt_clk` period = 2·HALF_DIV `clk` cycles. The first rising edge after reset occurs HALF_DIV cycles after `rst` deasserts.
- Acceptance to `tx` falling: 1 to 2·HALF_DIV `clk` cycles (next fall event).
- Frame length: 10 `usrt_clk` periods = 20·HALF_DIV `clk` cycles, measured from the start-bit falling edge to the fall event that raises `ready`.
- `tx`, `ready` and `usrt_clk` are registered outputs with no combinational path from inputs.
- Throughput: one byte per 10 bit periods plus 0–1 period alignment.

## Test plan
1. **Reset:** assert `rst` for 100 ns, then release → `tx`=1, `ready`=1, `usrt_clk`=0 during reset. With HALF_DIV=1 and `clk`=10 ns, `usrt_clk` toggles every 10 ns afterwards.
2. **Single byte:** `data`=8'hA5, one-cycle `send` → `ready` falls next edge. On `usrt_clk` rising edges `tx` reads 0,1,0,1,0,0,1,0,1,1. `ready` rises 20 `clk` cycles after the start bit begins.
3. **Send while busy:** during the frame of 8'h3C, pulse `send` with `data`=8'hFF → ignored, frame bits stay 0,0,0,1,1,1,1,0,0,1, and no second frame follows.
4. **Back-to-back:** hold `send` high with 8'h01 then 8'h80 → two correct frames, with the second start bit 1–2 bit periods after the first stop bit begins.
5. **Reset mid-frame:** assert `rst` after the 4th data bit → `tx`=1 and `ready`=1 immediately. A fresh send of 8'h55 afterwards produces a complete, correct frame.
6. **Loopback, HALF_DIV=3:** connect to `usrt_rec` and send 8'h3C → `usrt_clk` period is 60 ns, `usrt_rec` pulses `rdy` once with `data`=8'h3C.
